flap_input_sched: RTL and testbench
===================================

Name: flap_input_sched

Overview:
- Sequences player click events into the game datapath.
- Takes synchronized one-cycle click pulses: local mouse for player 1, remote UART for player 2.
- In GAME, gates clicks per player with a frame-based cooldown and releases them as frame-aligned flap pulses on vsync.
- In START and GAMEOVER, arbitrates both sources into single start/restart requests for game_fsm; GAMEOVER adds a hold-off.

Parameters:
- COOLDOWN_FRAMES, 6, frames a player is blocked after an issued flap (1..255).
- GAMEOVER_HOLD_FRAMES, 60, frames after entering GAMEOVER during which clicks are ignored (0..255).
- CNT_W, 8, width of cooldown, hold and drop counters.

Ports:
- clk  in  1  pixel clock (65 MHz); single clock domain.
- rst  in  1  synchronous, active-high reset.
- vsync  in  1  vertical sync from vga_timing; active-high.
- state  in  2  game_fsm state: 2'b00 START, 2'b01 GAME, 2'b10 GAMEOVER, 2'b11 treated as START.
- game_rst  in  1  one-cycle game reset pulse from game_fsm.
- click_local  in  1  one-cycle click pulse, player 1 (already synchronized and edge-detected).
- click_remote  in  1  one-cycle click pulse, player 2 (already synchronized and edge-detected).
- flap_p1  out  1  one-cycle flap pulse to draw_game, player 1.
- flap_p2  out  1  one-cycle flap pulse to draw_game, player 2.
- start_req  out  1  one-cycle request START->GAME.
- restart_req  out  1  one-cycle request GAMEOVER->START.
- cooldown_p1  out  1  high while player 1 cooldown counter is nonzero.
- cooldown_p2  out  1  high while player 2 cooldown counter is nonzero.
- drop_cnt  out  CNT_W  saturating count of GAME-state clicks rejected by cooldown, both players; cleared by rst/game_rst.

Behaviour:
- Reset: all outputs 0, all counters 0, pending flags 0, vsync_d 0, state_d 2'b00.
- Frame tick: frame_tick = vsync & ~vsync_d, with vsync_d registered each cycle. Exactly one tick per frame.
- GAME, click handling per player:
  - Click with cooldown==0 sets pend.
  - Click with cooldown!=0 is dropped; drop_cnt increments and saturates at all-ones. Both players dropping in the same cycle adds 2, saturating.
  - Repeated clicks while pend=1 merge into one flap; no drop counted.
- GAME, flap release:
  - On a frame_tick cycle, if (pend | accepted click this cycle), the registered flap_px is high in the next cycle for exactly 1 cycle.
  - pend clears and cooldown loads COOLDOWN_FRAMES.
  - Latency from the tick is 1 cycle. Both players may flap on the same tick.
- Cooldown:
  - Decrements by 1 on each frame_tick where it was nonzero and no load occurs.
  - A load takes precedence over a decrement on the same tick.
  - The load frame does not count: player becomes eligible on the COOLDOWN_FRAMES-th tick after the flap tick.
- START:
  - Any click_local|click_remote produces start_req high for 1 cycle, registered, on the next cycle.
  - Simultaneous clicks produce one pulse.
  - Further clicks while start_req is high are ignored; no frame alignment.
- GAMEOVER:
  - On entry (state_d != GAMEOVER and state == GAMEOVER), hold loads GAMEOVER_HOLD_FRAMES.
  - hold decrements on each frame_tick while nonzero.
  - Clicks are ignored while hold != 0.
  - When hold == 0, any click produces restart_req for 1 cycle (same timing as start_req).
  - GAMEOVER_HOLD_FRAMES=0 allows restart immediately.
- State exit from GAME: pend_p1/pend_p2 clear on the first cycle state != GAME; no flap is issued. Cooldowns keep decrementing on ticks.
- game_rst: clears pend, cooldowns and drop_cnt in the same edge; flap outputs are forced 0 next cycle. game_rst wins over a simultaneous click or tick.
- Outputs are mutually consistent: flap_px only in GAME, start_req only in START, restart_req only in GAMEOVER (judged on state at the click cycle).
- rst mid-operation: all state returns to reset values on the next edge; no pulse is issued that cycle.

Test Plan:
- Cooldown spacing: state=GAME, COOLDOWN_FRAMES=6, click_local 100 cycles before a tick -> flap_p1 one cycle after the tick. A second click 2 frames later -> dropped, drop_cnt=1, no flap. A click after the 6th tick -> flap_p1 on the next tick.
- Tick coincidence: click_remote in the same cycle as frame_tick, cooldown 0 -> flap_p2 the next cycle. Three clicks in one frame -> one flap_p2, drop_cnt unchanged.
- Both players: click_local and click_remote in the same cycle -> flap_p1 and flap_p2 asserted together after the next tick; cooldown_p1=cooldown_p2=1.
- START arbitration: state=START, click_local and click_remote simultaneous -> exactly one start_req pulse, 1 cycle after the clicks. state=GAME with pending click then switch to GAMEOVER -> no flap.
- GAMEOVER hold: GAMEOVER_HOLD_FRAMES=3, enter GAMEOVER, click after 1 tick -> no restart_req. Click after 3 ticks -> restart_req for 1 cycle.
- Reset priority: pend_p1 set, game_rst asserted on the tick cycle -> no flap_p1, cooldown 0, drop_cnt 0. rst high -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/flap_input_sched.sv
// Click scheduler: frame-aligned, cooldown-gated flap pulses in GAME, and
// single start/restart requests in START/GAMEOVER for game_fsm.
module flap_input_sched #(
  parameter int COOLDOWN_FRAMES      = 6,
  parameter int GAMEOVER_HOLD_FRAMES = 60,
  parameter int CNT_W                = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic [1:0]       state,
  input  logic             game_rst,
  input  logic             click_local,
  input  logic             click_remote,
  output logic             flap_p1,
  output logic             flap_p2,
  output logic             start_req,
  output logic             restart_req,
  output logic             cooldown_p1,
  output logic             cooldown_p2,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [1:0]       ST_START  = 2'b00;
  localparam logic [1:0]       ST_GAME   = 2'b01;
  localparam logic [1:0]       ST_OVER   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(GAMEOVER_HOLD_FRAMES);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) sat_add = CNT_MAX;
    else            sat_add = sum[CNT_W-1:0];
  endfunction

  // Index 0 is player 1 (local mouse), index 1 is player 2 (remote UART).
  logic                  vsync_d_r, hold_nz_s, hold_open_s, entry_s;
  logic [1:0]            state_d_r, click_s, pend_r, flap_r, cool_flag_r;
  logic [1:0]            cool_nz_s, accept_s, drop_s, release_s, pend_nxt_s;
  logic [1:0]            drop_inc_s;
  logic [1:0][CNT_W-1:0] cool_r, cool_nxt_s;
  logic [CNT_W-1:0]      hold_r, hold_nxt_s, drop_cnt_r;
  logic                  start_req_r, restart_req_r, start_nxt_s, restart_nxt_s;
  logic                  frame_tick_s, in_game_s, in_over_s, in_start_s;

  // Next-state decode for the per-player gates, the hold-off and the menu requests.
  always_comb begin
    frame_tick_s = vsync & ~vsync_d_r;
    click_s      = {click_remote, click_local};
    in_game_s    = 1'b0;
    in_over_s    = 1'b0;
    in_start_s   = 1'b0;
    case (state)
      ST_GAME:  in_game_s  = 1'b1;
      ST_OVER:  in_over_s  = 1'b1;
      ST_START: in_start_s = 1'b1;
      default:  in_start_s = 1'b1;
    endcase

    for (int i = 0; i < 2; i++) begin
      cool_nz_s[i] = (cool_r[i] != CNT_ZERO);
      accept_s[i]  = in_game_s & click_s[i] & ~cool_nz_s[i];
      drop_s[i]    = in_game_s & click_s[i] & cool_nz_s[i];
      release_s[i] = in_game_s & frame_tick_s & (pend_r[i] | accept_s[i]);
      // The release tick reloads rather than decrements, so it is not counted.
      if (release_s[i])                      cool_nxt_s[i] = COOL_LOAD;
      else if (frame_tick_s && cool_nz_s[i]) cool_nxt_s[i] = cool_r[i] - CNT_ONE;
      else                                   cool_nxt_s[i] = cool_r[i];
      if (!in_game_s || release_s[i]) pend_nxt_s[i] = 1'b0;
      else if (accept_s[i])           pend_nxt_s[i] = 1'b1;
      else                            pend_nxt_s[i] = pend_r[i];
    end
    drop_inc_s = {1'b0, drop_s[0]} + {1'b0, drop_s[1]};

    entry_s   = in_over_s & (state_d_r != ST_OVER);
    hold_nz_s = (hold_r != CNT_ZERO);
    if (entry_s)                        hold_nxt_s = HOLD_LOAD;
    else if (frame_tick_s && hold_nz_s) hold_nxt_s = hold_r - CNT_ONE;
    else                                hold_nxt_s = hold_r;
    // On the entry cycle the counter is stale; judge by the value being loaded.
    if (entry_s) hold_open_s = (HOLD_LOAD == CNT_ZERO);
    else         hold_open_s = ~hold_nz_s;

    start_nxt_s   = in_start_s & (click_local | click_remote) & ~start_req_r;
    restart_nxt_s = in_over_s & hold_open_s & (click_local | click_remote) & ~restart_req_r;
  end

  // Player datapath: pending clicks, cooldowns, flap pulses and drop counter.
  always_ff @(posedge clk) begin
    if (rst || game_rst) begin
      pend_r      <= 2'b00;
      cool_r      <= {2{CNT_ZERO}};
      cool_flag_r <= 2'b00;
      flap_r      <= 2'b00;
      drop_cnt_r  <= CNT_ZERO;
    end else begin
      pend_r      <= pend_nxt_s;
      cool_r      <= cool_nxt_s;
      cool_flag_r <= {(cool_nxt_s[1] != CNT_ZERO), (cool_nxt_s[0] != CNT_ZERO)};
      flap_r      <= release_s;
      drop_cnt_r  <= sat_add(drop_cnt_r, drop_inc_s);
    end
  end

  // Frame edge detector, state history, hold-off and menu request pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_r     <= 1'b0;
      state_d_r     <= ST_START;
      hold_r        <= CNT_ZERO;
      start_req_r   <= 1'b0;
      restart_req_r <= 1'b0;
    end else begin
      vsync_d_r     <= vsync;
      state_d_r     <= state;
      hold_r        <= hold_nxt_s;
      start_req_r   <= start_nxt_s;
      restart_req_r <= restart_nxt_s;
    end
  end

  assign flap_p1     = flap_r[0];
  assign flap_p2     = flap_r[1];
  assign cooldown_p1 = cool_flag_r[0];
  assign cooldown_p2 = cool_flag_r[1];
  assign start_req   = start_req_r;
  assign restart_req = restart_req_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_flap_input_sched.sv
// Directed bench for flap_input_sched: expected pulses are queued by cycle
// and checked every cycle; counters and cooldown flags are checked in line.
module tb_flap_input_sched;

  logic       clk = 1'b0, rst = 1'b1, vsync = 1'b0, game_rst = 1'b0;
  logic       click_local = 1'b0, click_remote = 1'b0;
  logic [1:0] state = 2'b00;
  logic       flap_p1, flap_p2, start_req, restart_req, cooldown_p1, cooldown_p2;
  logic [7:0] drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected pulse vector {flap_p1, flap_p2, start_req, restart_req} at a cycle.
  typedef struct { int cyc; logic [3:0] vec; } exp_t;
  exp_t q[$];

  flap_input_sched #(.COOLDOWN_FRAMES(6), .GAMEOVER_HOLD_FRAMES(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .state(state), .game_rst(game_rst),
    .click_local(click_local), .click_remote(click_remote),
    .flap_p1(flap_p1), .flap_p2(flap_p2), .start_req(start_req), .restart_req(restart_req),
    .cooldown_p1(cooldown_p1), .cooldown_p2(cooldown_p2), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every cycle the pulse outputs must match the queued expectation, else all zero.
  always @(negedge clk) begin
    logic [3:0] ev;
    ev = 4'b0000;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      ev = q[0].vec;
      void'(q.pop_front());
    end
    check("pulses", {28'd0, flap_p1, flap_p2, start_req, restart_req}, {28'd0, ev});
  end

  task automatic expect_pulse(input logic [3:0] v);
    q.push_back('{cyc + 1, v});
  endtask

  task automatic step(input logic cl, input logic cr, input logic vs);
    click_local = cl; click_remote = cr; vsync = vs;
    @(posedge clk); #1;
    click_local = 1'b0; click_remote = 1'b0; vsync = 1'b0; game_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    step(1'b0, 1'b0, 1'b1);
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(2);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_cooldown_p1", cooldown_p1, 0);
    check("rst_cooldown_p2", cooldown_p2, 0);
    rst = 1'b0;
    state = 2'b01;
    idle(2);

    // Cooldown spacing for player 1.
    step(1'b1, 1'b0, 1'b0);
    idle(100);
    expect_pulse(4'b1000);
    frame();
    check("cool1_after_flap", cooldown_p1, 1);
    frame(); frame();
    step(1'b1, 1'b0, 1'b0);
    check("drop_in_cooldown", drop_cnt, 1);
    frame(); frame(); frame();
    check("cool1_before_6th", cooldown_p1, 1);
    frame();
    check("cool1_after_6th", cooldown_p1, 0);
    step(1'b1, 1'b0, 1'b0);
    expect_pulse(4'b1000);
    frame();

    // Click coincident with the tick, then merged clicks for player 2.
    expect_pulse(4'b0100);
    step(1'b0, 1'b1, 1'b1);
    check("cool2_after_flap", cooldown_p2, 1);
    idle(3);
    for (int i = 0; i < 6; i++) frame();
    check("cool2_expired", cooldown_p2, 0);
    step(1'b0, 1'b1, 1'b0); idle(2);
    step(1'b0, 1'b1, 1'b0); idle(2);
    step(1'b0, 1'b1, 1'b0);
    check("merge_no_drop", drop_cnt, 1);
    expect_pulse(4'b0100);
    frame();

    // Both players in the same cycle, then a double drop.
    for (int i = 0; i < 6; i++) frame();
    step(1'b1, 1'b1, 1'b0);
    idle(5);
    expect_pulse(4'b1100);
    frame();
    check("both_cool", {cooldown_p1, cooldown_p2}, 2'b11);
    step(1'b1, 1'b1, 1'b0);
    check("double_drop", drop_cnt, 3);

    // Pending click abandoned on GAMEOVER; hold-off then restart.
    for (int i = 0; i < 6; i++) frame();
    step(1'b1, 1'b0, 1'b0);
    state = 2'b10;
    step(1'b0, 1'b0, 1'b0);
    frame();
    step(1'b1, 1'b0, 1'b0);
    frame(); frame();
    expect_pulse(4'b0001);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);

    // START arbitration: one request for simultaneous clicks.
    state = 2'b00;
    step(1'b0, 1'b0, 1'b0);
    expect_pulse(4'b0010);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    check("start_no_drop", drop_cnt, 3);

    // game_rst beats a simultaneous tick and clicks.
    state = 2'b01;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_pulse(4'b1000);
    frame();
    step(1'b0, 1'b1, 1'b0);
    game_rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    check("grst_drop_cnt", drop_cnt, 0);
    check("grst_cool", {cooldown_p1, cooldown_p2}, 2'b00);
    idle(2);
    frame();

    // Drop counter saturation, then rst mid-operation.
    expect_pulse(4'b1100);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 130; i++) step(1'b1, 1'b1, 1'b0);
    check("drop_saturate", drop_cnt, 255);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    check("rst_mid_drop", drop_cnt, 0);
    check("rst_mid_cool", {cooldown_p1, cooldown_p2}, 2'b00);
    rst = 1'b0;
    state = 2'b00;
    step(1'b0, 1'b0, 1'b0);
    expect_pulse(4'b0010);
    step(1'b1, 1'b0, 1'b0);
    idle(3);

    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
